// File: rtl/sd_sector_bridge_pkg.sv
// -----------------------------------------------------------------------------
// sd_bridge_pkg
// Shared types and constants for the SD sector bridge: the request FSM state
// encoding, the transfer direction and the geometry of one SD sector.
// -----------------------------------------------------------------------------
package sd_bridge_pkg;

    // Request sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_e;

    // Transfer direction as seen from the SD card
    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } dir_e;

    localparam int SECTOR_BYTES = 512;
    localparam int SECTOR_AW    = 9;

endpackage : sd_bridge_pkg

// File: rtl/sd_sector_bridge_dpram.sv
// -----------------------------------------------------------------------------
// dpram
// Generic true dual-port RAM, one clock, registered read data on both ports
// (read-before-write on the same port). Contents are not reset.
//
// Ports:
//   clk_i                 clock
//   a_addr_i / b_addr_i   port address
//   a_din_i  / b_din_i    port write data
//   a_we_i   / b_we_i     port write enable
//   a_dout_o / b_dout_o   port read data, one cycle after the address
// -----------------------------------------------------------------------------
module dpram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_din_i,
    input  logic              a_we_i,
    output logic [DATA_W-1:0] a_dout_o,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_din_i,
    input  logic              b_we_i,
    output logic [DATA_W-1:0] b_dout_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

    // Storage update and registered read for both ports
    always_ff @(posedge clk_i) begin
        if (a_we_i) begin
            mem_q[a_addr_i] <= a_din_i;
        end
        if (b_we_i) begin
            mem_q[b_addr_i] <= b_din_i;
        end
        a_dout_o <= mem_q[a_addr_i];
        b_dout_o <= mem_q[b_addr_i];
    end

endmodule : dpram

// File: rtl/sd_sector_bridge.sv
// -----------------------------------------------------------------------------
// sd_sector_bridge
// Sector buffer and request sequencer between the CPU-side glue and the hps_io
// SD block interface. Holds SECTORS 512-byte slots; a request copies one SD
// sector into a slot (read) or one slot out to the card (write).
//
// Ports:
//   clk_100m, reset            sole clock, synchronous active-high reset
//   req_rd / req_wr            one-cycle request pulses (read wins if both)
//   req_lba / req_slot         block address and slot, sampled with req_*
//   busy, done, timeout_err    status: busy level, done / abort pulses
//   cpu_addr/din/wr, cpu_dout  CPU byte port {slot, offset}, 1-cycle read
//   sd_lba, sd_rd, sd_wr       request to hps_io
//   sd_ack, sd_buff_*          hps_io handshake and buffer port
// -----------------------------------------------------------------------------
module sd_sector_bridge
    import sd_bridge_pkg::*;
#(
    parameter int SECTORS = 2,
    parameter int SLOT_W  = (SECTORS > 1) ? $clog2(SECTORS) : 1,
    parameter int LBA_W   = 32,
    parameter int TIMEOUT = 100_000_000
) (
    input  logic                        clk_100m,
    input  logic                        reset,
    input  logic                        req_rd,
    input  logic                        req_wr,
    input  logic [LBA_W-1:0]            req_lba,
    input  logic [SLOT_W-1:0]           req_slot,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout_err,
    input  logic [SLOT_W+SECTOR_AW-1:0] cpu_addr,
    input  logic [7:0]                  cpu_din,
    input  logic                        cpu_wr,
    output logic [7:0]                  cpu_dout,
    output logic [LBA_W-1:0]            sd_lba,
    output logic                        sd_rd,
    output logic                        sd_wr,
    input  logic                        sd_ack,
    input  logic [SECTOR_AW-1:0]        sd_buff_addr,
    input  logic [7:0]                  sd_buff_dout,
    output logic [7:0]                  sd_buff_din,
    input  logic                        sd_buff_wr
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    dir_e               dir_q, dir_d;
    logic [LBA_W-1:0]   lba_q, lba_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tmo_q, tmo_d;
    logic               sd_rd_q, sd_rd_d;
    logic               sd_wr_q, sd_wr_d;
    logic               wd_hit_s;
    logic               cpu_we_s;
    logic [SLOT_W-1:0]  cpu_slot_s;

    assign wd_hit_s   = (wd_q == WD_LAST);
    assign cpu_slot_s = cpu_addr[SLOT_W+SECTOR_AW-1 -: SLOT_W];

    // The HPS side only ever touches slot_q, so masking CPU writes to that
    // slot while busy removes any chance of a same-address port collision.
    assign cpu_we_s = cpu_wr & ~(busy_q & (cpu_slot_s == slot_q));

    // Next-state, watchdog and registered-output decode
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        lba_d   = lba_q;
        slot_d  = slot_q;
        wd_d    = wd_q;
        tmo_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_rd || req_wr) begin
                    state_d = REQ;
                    dir_d   = req_rd ? RD : WR;
                    lba_d   = req_lba;
                    slot_d  = req_slot;
                    wd_d    = {WD_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (wd_hit_s) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    wd_d    = wd_q + {{(WD_W-1){1'b0}}, 1'b1};
                    state_d = sd_ack ? XFER : REQ;
                end
            end
            XFER: begin
                if (wd_hit_s) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    wd_d    = wd_q + {{(WD_W-1){1'b0}}, 1'b1};
                    state_d = sd_ack ? XFER : DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so that the registered
        // request drops on the same edge that sees sd_ack (or the abort).
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        sd_rd_d = (state_d == REQ) && (dir_d == RD);
        sd_wr_d = (state_d == REQ) && (dir_d == WR);
    end

    // State and output registers
    always_ff @(posedge clk_100m) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= RD;
            lba_q   <= {LBA_W{1'b0}};
            slot_q  <= {SLOT_W{1'b0}};
            wd_q    <= {WD_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            lba_q   <= lba_d;
            slot_q  <= slot_d;
            wd_q    <= wd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            sd_rd_q <= sd_rd_d;
            sd_wr_q <= sd_wr_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = tmo_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign sd_lba      = lba_q;

    dpram #(
        .ADDR_W (SLOT_W + SECTOR_AW),
        .DATA_W (8)
    ) u_buf (
        .clk_i    (clk_100m),
        .a_addr_i ({slot_q, sd_buff_addr}),
        .a_din_i  (sd_buff_dout),
        .a_we_i   (sd_buff_wr),
        .a_dout_o (sd_buff_din),
        .b_addr_i (cpu_addr),
        .b_din_i  (cpu_din),
        .b_we_i   (cpu_we_s),
        .b_dout_o (cpu_dout)
    );

endmodule : sd_sector_bridge

// File: tb/tb_sd_sector_bridge.sv
module tb_sd_sector_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (long watchdog so full sectors can move)
    logic        reset;
    logic        req_rd, req_wr;
    logic [31:0] req_lba;
    logic [0:0]  req_slot;
    logic        busy, done, timeout_err;
    logic [9:0]  cpu_addr;
    logic [7:0]  cpu_din, cpu_dout;
    logic        cpu_wr;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout, sd_buff_din;
    logic        sd_buff_wr;

    // watchdog instance (TIMEOUT = 50, never acked)
    logic        t_req_rd, t_req_wr;
    logic [31:0] t_req_lba;
    logic [0:0]  t_req_slot;
    logic        t_busy, t_done, t_tmo;
    logic [9:0]  t_cpu_addr;
    logic [7:0]  t_cpu_din, t_cpu_dout;
    logic        t_cpu_wr;
    logic [31:0] t_sd_lba;
    logic        t_sd_rd, t_sd_wr, t_sd_ack;
    logic [8:0]  t_buff_addr;
    logic [7:0]  t_buff_dout, t_buff_din;
    logic        t_buff_wr;

    sd_sector_bridge #(.SECTORS(2), .LBA_W(32), .TIMEOUT(2000)) dut (
        .clk_100m(clk), .reset(reset),
        .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba), .req_slot(req_slot),
        .busy(busy), .done(done), .timeout_err(timeout_err),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr)
    );

    sd_sector_bridge #(.SECTORS(2), .LBA_W(32), .TIMEOUT(50)) dut_tmo (
        .clk_100m(clk), .reset(reset),
        .req_rd(t_req_rd), .req_wr(t_req_wr), .req_lba(t_req_lba), .req_slot(t_req_slot),
        .busy(t_busy), .done(t_done), .timeout_err(t_tmo),
        .cpu_addr(t_cpu_addr), .cpu_din(t_cpu_din), .cpu_wr(t_cpu_wr), .cpu_dout(t_cpu_dout),
        .sd_lba(t_sd_lba), .sd_rd(t_sd_rd), .sd_wr(t_sd_wr), .sd_ack(t_sd_ack),
        .sd_buff_addr(t_buff_addr), .sd_buff_dout(t_buff_dout),
        .sd_buff_din(t_buff_din), .sd_buff_wr(t_buff_wr)
    );

    int checks = 0;
    int errors = 0;

    // reference model: the whole buffer as a flat byte array
    logic [7:0] ref_mem [0:1023];

    // event counters sampled away from the active edge
    int done_cnt = 0, wr_cnt = 0, t_done_cnt = 0;
    always @(negedge clk) begin
        if (done)   done_cnt++;
        if (sd_wr)  wr_cnt++;
        if (t_done) t_done_cnt++;
    end

    typedef struct {
        logic [9:0] addr;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [9:0] a, input logic [7:0] d, input bit lands);
        @(negedge clk);
        cpu_addr = a; cpu_din = d; cpu_wr = 1'b1;
        @(negedge clk);
        cpu_wr = 1'b0;
        if (lands) ref_mem[a] = d;
    endtask

    task automatic cpu_read(input logic [9:0] a, output logic [7:0] d);
        @(negedge clk);
        cpu_addr = a; cpu_wr = 1'b0;
        @(negedge clk);
        d = cpu_dout;
    endtask

    task automatic chk_mem(input logic [9:0] a);
        logic [7:0] d;
        cpu_read(a, d);
        chk($sformatf("mem[%03h]", a), {24'd0, d}, {24'd0, ref_mem[a]});
    endtask

    task automatic verify_all();
        for (int a = 0; a < 1024; a++) chk_mem(10'(a));
    endtask

    task automatic req(input bit rd, input bit wr, input logic [31:0] lba, input logic s);
        @(negedge clk);
        req_rd = rd; req_wr = wr; req_lba = lba; req_slot = s;
        @(negedge clk);
        req_rd = 1'b0; req_wr = 1'b0;
        chk("busy_rise", busy, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        chk("idle_reached", busy, 0);
        @(negedge clk);
    endtask

    // HPS-side model: waits for the request, acks 3 cycles later, moves
    // nbytes (pattern offset^0x5A or random data for reads), then drops ack.
    task automatic serve(input bit is_rd, input logic [31:0] lba, input logic s,
                         input int nbytes, input bit rnd);
        int n = 0;
        int d0 = done_cnt;
        logic [7:0] b;
        while (!(is_rd ? sd_rd : sd_wr) && n < 20) begin @(negedge clk); n++; end
        chk("req_seen", is_rd ? sd_rd : sd_wr, 1);
        chk("sd_lba", sd_lba, lba);
        repeat (3) @(negedge clk);
        chk("req_held", is_rd ? sd_rd : sd_wr, 1);
        sd_ack = 1'b1;
        @(negedge clk);
        chk("req_drop_after_ack", {31'd0, sd_rd | sd_wr}, 0);
        chk("busy_in_xfer", busy, 1);
        if (is_rd) begin
            for (int i = 0; i < nbytes; i++) begin
                b = rnd ? 8'($urandom) : (8'(i) ^ 8'h5A);
                sd_buff_addr = 9'(i); sd_buff_dout = b; sd_buff_wr = 1'b1;
                ref_mem[{s, 9'(i)}] = b;
                @(negedge clk);
            end
            sd_buff_wr = 1'b0;
        end else begin
            for (int i = 0; i < nbytes; i++) begin
                sd_buff_addr = 9'(i);
                @(negedge clk);
                chk($sformatf("buff_din[%0d]", i), {24'd0, sd_buff_din}, {24'd0, ref_mem[{s, 9'(i)}]});
            end
        end
        sd_ack = 1'b0;
        wait_idle();
        chk("done_once", done_cnt - d0, 1);
    endtask

    initial begin
        #500_000;
        $display("FAIL global_time_limit: simulation did not complete, expected completion");
        $fatal(1);
    end

    initial begin
        int c, w0, d0;
        logic [7:0] d;
        logic s;
        logic [31:0] l;

        reset = 1'b1;
        req_rd = 0; req_wr = 0; req_lba = 0; req_slot = 0;
        cpu_addr = 0; cpu_din = 0; cpu_wr = 0;
        sd_ack = 0; sd_buff_addr = 0; sd_buff_dout = 0; sd_buff_wr = 0;
        t_req_rd = 0; t_req_wr = 0; t_req_lba = 0; t_req_slot = 0;
        t_cpu_addr = 0; t_cpu_din = 0; t_cpu_wr = 0;
        t_sd_ack = 0; t_buff_addr = 0; t_buff_dout = 0; t_buff_wr = 0;

        vecs[0] = '{10'h000, 8'h11, 8'h11};
        vecs[1] = '{10'h1FF, 8'h22, 8'h22};
        vecs[2] = '{10'h200, 8'h33, 8'h44};
        vecs[3] = '{10'h3FF, 8'h55, 8'h55};
        vecs[4] = '{10'h200, 8'h44, 8'h44};
        vecs[5] = '{10'h0AA, 8'hFF, 8'hFF};
        vecs[6] = '{10'h155, 8'h00, 8'h00};
        vecs[7] = '{10'h2AA, 8'h5A, 8'h5A};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_sd_rd", sd_rd, 0);
        chk("rst_sd_wr", sd_wr, 0);
        chk("rst_sd_lba", sd_lba, 0);

        // random fill of both slots through the CPU port
        for (int a = 0; a < 1024; a++) cpu_write(10'(a), 8'($urandom), 1'b1);

        // table vectors: boundary addresses and an overwrite
        foreach (vecs[i]) cpu_write(vecs[i].addr, vecs[i].din, 1'b1);
        foreach (vecs[i]) begin
            cpu_read(vecs[i].addr, d);
            chk($sformatf("vec%0d", i), {24'd0, d}, {24'd0, vecs[i].exp});
        end

        // read lba 0x1234 into slot 1
        req(1'b1, 1'b0, 32'h1234, 1'b1);
        serve(1'b1, 32'h1234, 1'b1, 512, 1'b0);
        verify_all();

        // write: slot 0 filled with 0xA5 goes out to lba 7
        for (int a = 0; a < 512; a++) cpu_write(10'(a), 8'hA5, 1'b1);
        req(1'b0, 1'b1, 32'd7, 1'b0);
        serve(1'b0, 32'd7, 1'b0, 512, 1'b0);

        // busy rules during XFER of slot 1
        w0 = wr_cnt; d0 = done_cnt;
        req(1'b1, 1'b0, 32'h55, 1'b1);
        c = 0;
        while (!sd_rd && c < 20) begin @(negedge clk); c++; end
        chk("busy_test_rd", sd_rd, 1);
        sd_ack = 1'b1;
        @(negedge clk);
        req_wr = 1'b1; req_lba = 32'h99; req_slot = 1'b0;
        @(negedge clk);
        req_wr = 1'b0;
        cpu_write(10'h210, 8'hEE, 1'b0);
        cpu_write(10'h010, 8'hCC, 1'b1);
        chk("lba_kept", sd_lba, 32'h55);
        sd_ack = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        chk("ignored_req_busy", busy, 0);
        chk("ignored_req_wr", wr_cnt - w0, 0);
        chk("busy_test_done", done_cnt - d0, 1);
        chk_mem(10'h210);
        chk_mem(10'h010);

        // simultaneous req_rd and req_wr: read wins
        w0 = wr_cnt;
        req(1'b1, 1'b1, 32'd3, 1'b0);
        serve(1'b1, 32'd3, 1'b0, 0, 1'b0);
        chk("simul_no_wr", wr_cnt - w0, 0);

        // random transfers in both directions
        for (int k = 0; k < 4; k++) begin
            s = 1'($urandom);
            l = $urandom;
            req(k % 2 == 0, k % 2 != 0, l, s);
            serve(k % 2 == 0, l, s, 512, 1'b1);
        end
        verify_all();

        // watchdog abort on the TIMEOUT=50 instance
        @(negedge clk);
        t_req_rd = 1'b1; t_req_lba = 32'hABC; t_req_slot = 1'b0;
        @(negedge clk);
        t_req_rd = 1'b0;
        chk("tmo_busy_rise", t_busy, 1);
        c = 0;
        while (!t_tmo && c < 200) begin @(negedge clk); c++; end
        chk("tmo_cycle", c, 50);
        chk("tmo_sd_rd", t_sd_rd, 0);
        chk("tmo_busy", t_busy, 0);
        chk("tmo_no_done", t_done_cnt, 0);
        @(negedge clk);
        chk("tmo_pulse", t_tmo, 0);

        // reset in the middle of REQ
        req(1'b1, 1'b0, 32'h77, 1'b0);
        c = 0;
        while (!sd_rd && c < 20) begin @(negedge clk); c++; end
        chk("midreq_rd", sd_rd, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midreq_sd_rd", sd_rd, 0);
        chk("midreq_busy", busy, 0);
        chk("midreq_lba", sd_lba, 0);
        reset = 1'b0;
        req(1'b1, 1'b0, 32'h42, 1'b1);
        serve(1'b1, 32'h42, 1'b1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_sector_bridge.md
Name: sd_sector_bridge

Overview:
- Parametrised SD sector buffer and request sequencer between the core's CPU-side glue logic and the hps_io SD block interface.
- Replaces the fixed single-sector, LBA-0 buffer arrangement with:
  - SECTORS independent 512-byte buffer slots;
  - a latched, driven sd_lba;
  - a read/write FSM with an ack handshake, a done pulse and a watchdog timeout.
- Instantiated in emu between glue and hps_io; runs entirely on clk_100m.

Parameters:
- SECTORS, 2, number of 512-byte buffer slots (power of two, >=1).
- SLOT_W, (SECTORS>1 ? $clog2(SECTORS) : 1), slot index width (derived; not overridden).
- LBA_W, 32, width of the block address.
- TIMEOUT, 100_000_000, clk_100m cycles allowed per request (REQ+XFER) before abort; 1 s at 100 MHz.

Ports:
- clk_100m  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- req_rd  in  1  one-cycle pulse: read sector req_lba into slot req_slot.
- req_wr  in  1  one-cycle pulse: write slot req_slot to sector req_lba.
- req_lba  in  LBA_W  block address, sampled with req_*.
- req_slot  in  SLOT_W  buffer slot, sampled with req_*.
- busy  out  1  high from accept until return to IDLE.
- done  out  1  one-cycle pulse on successful completion.
- timeout_err  out  1  one-cycle pulse on watchdog abort.
- cpu_addr  in  SLOT_W+9  CPU byte address {slot, offset}.
- cpu_din  in  8  CPU write data.
- cpu_wr  in  1  CPU byte write strobe.
- cpu_dout  out  8  CPU read data, 1-cycle latency.
- sd_lba  out  LBA_W  to hps_io.
- sd_rd  out  1  to hps_io.
- sd_wr  out  1  to hps_io.
- sd_ack  in  1  from hps_io.
- sd_buff_addr  in  9  from hps_io.
- sd_buff_dout  in  8  from hps_io: data from the HPS.
- sd_buff_din  out  8  to hps_io: data to the HPS, 1-cycle latency.
- sd_buff_wr  in  1  from hps_io.

Behaviour:
- Clocking and reset: one clock (clk_100m); reset is synchronous and active-high.
- Reset values: state IDLE; busy, done, timeout_err, sd_rd, sd_wr = 0; sd_lba = 0; watchdog count = 0. RAM contents are not reset.
- Buffer: true dual-port RAM, depth SECTORS*512 x 8.
  - Port A (HPS side) address = {slot_q, sd_buff_addr}; written by sd_buff_dout when sd_buff_wr; read data to sd_buff_din.
  - Port B (CPU side) address = cpu_addr.
- FSM states: IDLE, REQ, XFER, DONE.
- IDLE:
  - req_rd or req_wr -> latch lba_q, slot_q and dir_q -> REQ. busy rises next cycle.
  - req_rd and req_wr in the same cycle: read wins.
- REQ:
  - sd_rd = dir_q==RD & ~sd_ack; sd_wr = dir_q==WR & ~sd_ack. Both are registered, and the request deasserts the cycle after sd_ack is seen high.
  - sd_ack high -> XFER.
- XFER: sd_ack low -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE; busy falls with the return to IDLE.
- sd_lba = lba_q, held stable from REQ until the next accept.
- Watchdog:
  - Counter clears on accept and increments in REQ and XFER.
  - When count == TIMEOUT-1: sd_rd/sd_wr drop, timeout_err pulses for 1 cycle, FSM goes to IDLE with no done pulse.
- req_rd/req_wr while busy are ignored: no queueing, no error.
- CPU writes while busy:
  - A cpu_wr whose slot field equals slot_q is dropped.
  - Writes to other slots proceed normally.
  - CPU reads are never blocked.
- Port collision is impossible by construction: the HPS side only touches slot_q, and CPU writes to slot_q are masked while busy.
- Reset mid-operation: FSM returns to IDLE on the next edge and sd_rd/sd_wr go low. If hps_io is still mid-transfer, sd_buff_wr writes still land in slot_q; the RAM stays consistent and is undefined only for the interrupted slot.

Decomposition:
- Package sd_bridge_pkg:
  - state enum (IDLE, REQ, XFER, DONE);
  - dir enum (RD, WR);
  - SECTOR_BYTES=512;
  - SECTOR_AW=9.
- One sub-module: the existing dpram reused with #(SLOT_W+SECTOR_AW, 8). No new RAM module.
- The FSM, watchdog and write masking live in sd_sector_bridge.

Test Plan:
- Read: req_rd, lba=0x1234, slot=1.
  - Bench asserts sd_ack 3 cycles after sd_rd and writes 512 bytes (value = offset^0x5A), then drops ack.
  - Required: sd_lba=0x1234; sd_rd falls the cycle after ack; done pulses once.
  - CPU reads at 0x200..0x3FF return offset^0x5A, and slot 0 is unchanged.
- Write: CPU fills slot 0 with 0xA5, then req_wr, lba=7, slot=0.
  - HPS model reads 512 bytes via sd_buff_addr.
  - Required: sd_wr seen, every sd_buff_din=0xA5 (1-cycle latency), done pulses once.
- Timeout: TIMEOUT=50, req_rd, sd_ack never asserted.
  - Required: timeout_err at cycle 50 after accept, sd_rd low, busy low, no done.
- Busy rules: during the XFER of slot 1, issue req_wr and a cpu_wr to 0x210 and to 0x010.
  - Required: the request is ignored, 0x210 is unchanged, 0x010 is updated.
- Simultaneous req_rd and req_wr in IDLE.
  - Required: sd_rd asserted, sd_wr never asserted.
- Reset mid-REQ: reset with sd_rd high.
  - Required: sd_rd=0 and busy=0 on the next edge, sd_lba=0, a new req_rd is accepted afterwards.
